// File: rtl/ro_scan_counter.sv
// ro_scan_counter: steps the six-input RO mux through its channels, waits a
// settle interval, counts RO rising edges over a programmable window and hands
// each count out on a valid/ready result port.
// Optional feature macro: RO_SCAN_MASK_EN adds CH_MASK (per-channel enable,
// latched on START); without it all six channels are scanned.
//
// Result handshake: RESULT/RESULT_CH are presented with RESULT_VALID=1 and
// held unchanged until a rising CLK edge sees RESULT_VALID=1 and
// RESULT_READY=1; that edge is the transfer, and RESULT_VALID drops after it
// unless another result is already due (it never is: a new count needs at
// least SETTLE+1 further cycles).
module ro_scan_counter #(
    parameter int CNT_W  = 16,
    parameter int WIN_W  = 16,
    parameter int SETTLE = 4
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             START,
    input  logic [WIN_W-1:0] WINDOW,
    input  logic             RO_OUT,
    output logic [3:1]       S,
    output logic [CNT_W-1:0] RESULT,
    output logic [2:0]       RESULT_CH,
    output logic             RESULT_VALID,
    input  logic             RESULT_READY,
    output logic             BUSY,
    output logic             DONE
`ifdef RO_SCAN_MASK_EN
    ,
    input  logic [5:0]       CH_MASK
`endif
);

    // Timer must hold both the window length and the settle count.
    localparam int TMR_W = (WIN_W > $clog2(SETTLE + 1)) ? WIN_W : $clog2(SETTLE + 1);
    localparam logic [TMR_W-1:0] SET_LAST = TMR_W'(SETTLE - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_COUNT,
        ST_REPORT,
        ST_DRAIN
    } state_t;

    state_t             state;
    logic [2:0]         ch;
    logic [TMR_W-1:0]   tmr;
    logic [WIN_W-1:0]   win_last;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_next;
    logic               sync1;
    logic               sync2;
    logic               hist;
    logic               rise;
    logic [5:0]         mask_q;
    logic [5:0]         start_mask;
    logic [3:0]         first_idle;
    logic [3:0]         next_ch;

    // Lowest enabled channel at or above 'from'; bit 3 flags that one exists.
    function automatic logic [3:0] first_from(input logic [5:0] m, input logic [2:0] from);
        logic [3:0] r;
        r = 4'b0000;
        for (int k = 5; k >= 0; k--) begin
            if (m[k] && (3'(k) >= from)) r = {1'b1, 3'(k)};
        end
        return r;
    endfunction

    // Mux select code: RO0=111 down to RO5=010.
    function automatic logic [2:0] sel_code(input logic [2:0] c);
        return 3'd7 - c;
    endfunction

`ifdef RO_SCAN_MASK_EN
    assign start_mask = CH_MASK;
`else
    assign start_mask = 6'b111111;
    assign mask_q     = 6'b111111;
`endif

    assign rise       = sync2 & ~hist;
    assign cnt_next   = (rise && (cnt != {CNT_W{1'b1}})) ? cnt + 1'b1 : cnt;
    assign first_idle = first_from(start_mask, 3'd0);
    assign next_ch    = first_from(mask_q, ch + 3'd1);

    // RO synchronizer and edge history; free-running in every state.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            hist  <= 1'b0;
        end else begin
            sync1 <= RO_OUT;
            sync2 <= sync1;
            hist  <= sync2;
        end
    end

    // Scan FSM with registered select, counter and result outputs.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state        <= ST_IDLE;
            ch           <= 3'd0;
            tmr          <= '0;
            win_last     <= '0;
            cnt          <= '0;
            S            <= 3'b000;
            RESULT       <= '0;
            RESULT_CH    <= 3'd0;
            RESULT_VALID <= 1'b0;
            BUSY         <= 1'b0;
            DONE         <= 1'b0;
`ifdef RO_SCAN_MASK_EN
            mask_q       <= 6'b000000;
`endif
        end else begin
            DONE <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (START) begin
                        // A zero window is stretched to one cycle.
                        win_last <= (WINDOW == '0) ? '0 : WINDOW - 1'b1;
                        tmr      <= '0;
                        BUSY     <= 1'b1;
`ifdef RO_SCAN_MASK_EN
                        mask_q   <= CH_MASK;
`endif
                        if (first_idle[3]) begin
                            ch    <= first_idle[2:0];
                            S     <= sel_code(first_idle[2:0]);
                            state <= ST_SETTLE;
                        end else begin
                            state <= ST_DRAIN;
                        end
                    end
                end
                ST_SETTLE: begin
                    if (tmr == SET_LAST) begin
                        tmr   <= '0;
                        cnt   <= '0;
                        state <= ST_COUNT;
                    end else begin
                        tmr <= tmr + 1'b1;
                    end
                end
                ST_COUNT: begin
                    // An edge on the final window cycle still lands in RESULT.
                    cnt <= cnt_next;
                    if (tmr == TMR_W'(win_last)) begin
                        RESULT       <= cnt_next;
                        RESULT_CH    <= ch;
                        RESULT_VALID <= 1'b1;
                        state        <= ST_REPORT;
                    end else begin
                        tmr <= tmr + 1'b1;
                    end
                end
                ST_REPORT: begin
                    if (RESULT_READY) begin
                        RESULT_VALID <= 1'b0;
                        tmr          <= '0;
                        if (next_ch[3]) begin
                            ch    <= next_ch[2:0];
                            S     <= sel_code(next_ch[2:0]);
                            state <= ST_SETTLE;
                        end else begin
                            S     <= 3'b000;
                            BUSY  <= 1'b0;
                            DONE  <= 1'b1;
                            state <= ST_IDLE;
                        end
                    end
                end
                ST_DRAIN: begin
                    // Empty mask: one busy cycle, then finish with no results.
                    BUSY  <= 1'b0;
                    DONE  <= 1'b1;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ro_scan_counter.sv
// tb_ro_scan_counter: randomized scans of ro_scan_counter against a
// channel-list / edges-per-window reference model, plus a CNT_W=4 instance
// for saturation.
module tb_ro_scan_counter;

    localparam int SETTLE = 4;
    localparam int CNT_W  = 16;
    localparam int WIN_W  = 16;

    // ---------------- clock / reset ----------------
    logic CLK = 1'b0;
    logic RST_N = 1'b0;
    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // ---------------- DUT signals ----------------
    logic             START = 1'b0;
    logic [WIN_W-1:0] WINDOW = '0;
    logic             RO_OUT = 1'b0;
    logic             RESULT_READY = 1'b0;
    logic [5:0]       CH_MASK = 6'b111111;
    logic [3:1]       S;
    logic [CNT_W-1:0] RESULT;
    logic [2:0]       RESULT_CH;
    logic             RESULT_VALID;
    logic             BUSY;
    logic             DONE;

    logic             start2 = 1'b0;
    logic [WIN_W-1:0] window2 = '0;
    logic [3:1]       s2;
    logic [3:0]       result2;
    logic [2:0]       result_ch2;
    logic             valid2;
    logic             busy2;
    logic             done2;

    ro_scan_counter #(.CNT_W(CNT_W), .WIN_W(WIN_W), .SETTLE(SETTLE)) u_dut (
        .CLK(CLK), .RST_N(RST_N), .START(START), .WINDOW(WINDOW), .RO_OUT(RO_OUT),
        .S(S), .RESULT(RESULT), .RESULT_CH(RESULT_CH), .RESULT_VALID(RESULT_VALID),
        .RESULT_READY(RESULT_READY), .BUSY(BUSY), .DONE(DONE)
`ifdef RO_SCAN_MASK_EN
        , .CH_MASK(CH_MASK)
`endif
    );

    ro_scan_counter #(.CNT_W(4), .WIN_W(WIN_W), .SETTLE(SETTLE)) u_sat (
        .CLK(CLK), .RST_N(RST_N), .START(start2), .WINDOW(window2), .RO_OUT(RO_OUT),
        .S(s2), .RESULT(result2), .RESULT_CH(result_ch2), .RESULT_VALID(valid2),
        .RESULT_READY(1'b1), .BUSY(busy2), .DONE(done2)
`ifdef RO_SCAN_MASK_EN
        , .CH_MASK(6'b111111)
`endif
    );

    // ---------------- RO source: period ro_per clocks, changes on negedge ----------------
    int ro_per = 10;
    int ro_p;
    bit ro_en = 1'b0;
    initial forever begin
        if (ro_en) begin
            ro_p = ro_per;
            RO_OUT = 1'b1;
            repeat (ro_p / 2) @(negedge CLK);
            RO_OUT = 1'b0;
            repeat (ro_p - ro_p / 2) @(negedge CLK);
        end else begin
            RO_OUT = 1'b0;
            @(negedge CLK);
        end
    end

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail = 0;
    logic [CNT_W-1:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [2:0] code_of(input int c);
        logic [2:0] table6 [6];
        table6 = '{3'b111, 3'b110, 3'b101, 3'b100, 3'b011, 3'b010};
        return table6[c];
    endfunction

    // ---------------- driver: one full scan, checked against the model ----------------
    // per=0 turns the RO off; otherwise win must be a multiple of per so the
    // window holds exactly win/per rising edges whatever the phase.
    task automatic run_scan(input int win, input int per, input bit rnd_ready, input int long_ch);
        int weff, t, h, n, hold, exp_cnt, sat_max;
        int chs[$];
        weff = (win == 0) ? 1 : win;
        ro_per = (per == 0) ? 10 : per;
        ro_en = (per != 0);
        repeat (30) @(negedge CLK);
        chs = {};
        for (int k = 0; k < 6; k++) if (CH_MASK[k]) chs.push_back(k);
        sat_max = (1 << CNT_W) - 1;
        exp_cnt = (per == 0) ? 0 : weff / per;
        if (exp_cnt > sat_max) exp_cnt = sat_max;
        exp_q = {};
        foreach (chs[i]) exp_q.push_back(CNT_W'(exp_cnt));

        START = 1'b1;
        WINDOW = WIN_W'(win);
        @(negedge CLK);
        t = cyc;
        START = 1'b0;
        WINDOW = WIN_W'($urandom);
        check("busy_after_start", BUSY, 1);
        if (chs.size() == 0) begin
            @(negedge CLK);
            check("empty_busy_fall", BUSY, 0);
            check("empty_done", DONE, 1);
            check("empty_valid", RESULT_VALID, 0);
            @(negedge CLK);
            check("empty_done_end", DONE, 0);
            return;
        end
        check("s_first", S, code_of(chs[0]));
        h = t;
        foreach (chs[i]) begin
            n = 0;
            while (!RESULT_VALID && n < SETTLE + weff + 10) begin
                @(negedge CLK);
                n++;
            end
            check("valid_time", cyc, h + SETTLE + weff);
            check("result_ch", RESULT_CH, chs[i]);
            check("result", RESULT, exp_q[0]);
            check("s_count", S, code_of(chs[i]));
            hold = rnd_ready ? $urandom_range(0, 8) : 0;
            if (i == long_ch) hold = 50;
            for (int j = 0; j < hold; j++) begin
                START = (i == 0 && j == 1);
                RESULT_READY = 1'b0;
                @(negedge CLK);
                START = 1'b0;
                check("hold_valid", RESULT_VALID, 1);
                check("hold_result", RESULT, exp_q[0]);
                check("hold_s", S, code_of(chs[i]));
            end
            RESULT_READY = 1'b1;
            @(negedge CLK);
            h = cyc;
            RESULT_READY = 1'b0;
            void'(exp_q.pop_front());
            check("valid_drop", RESULT_VALID, 0);
            if (i == chs.size() - 1) begin
                check("done_pulse", DONE, 1);
                check("busy_end", BUSY, 0);
                check("s_idle", S, 0);
            end else begin
                check("s_next", S, code_of(chs[i + 1]));
                check("busy_mid", BUSY, 1);
                check("done_mid", DONE, 0);
            end
        end
        @(negedge CLK);
        check("done_once", DONE, 0);
        check("no_restart", BUSY, 0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int per, k, n;
        RST_N = 1'b0;
        repeat (3) @(negedge CLK);
        RST_N = 1'b1;
        repeat (20) @(negedge CLK);
        check("rst_s", S, 0);
        check("rst_valid", RESULT_VALID, 0);
        check("rst_busy", BUSY, 0);
        check("rst_done", DONE, 0);
        check("rst_result", RESULT, 0);
        check("rst_result_ch", RESULT_CH, 0);

        // Directed: period 10, window 100, ready high.
        run_scan(100, 10, 1'b0, -1);
        // Channel 2 stalls 50 cycles.
        run_scan(100, 10, 1'b1, 2);
        // Window 0 behaves as 1; window 1; RO off.
        run_scan(0, 0, 1'b0, -1);
        run_scan(1, 0, 1'b0, -1);

        // Randomized periods/windows/stalls.
        repeat (4) begin
            per = $urandom_range(5, 12);
            k = $urandom_range(1, 10);
`ifdef RO_SCAN_MASK_EN
            CH_MASK = 6'($urandom_range(1, 63));
`endif
            run_scan(per * k, per, 1'b1, -1);
        end
        CH_MASK = 6'b111111;

        // Reset mid-COUNT on channel 3.
        ro_per = 10;
        ro_en = 1'b1;
        RESULT_READY = 1'b1;
        START = 1'b1;
        WINDOW = 16'd100;
        @(negedge CLK);
        START = 1'b0;
        n = 0;
        while (S != 3'b100 && n < 2000) begin
            @(negedge CLK);
            n++;
        end
        check("reach_ch3", S, 3'b100);
        repeat (SETTLE + 10) @(negedge CLK);
        RST_N = 1'b0;
        @(negedge CLK);
        RST_N = 1'b1;
        RESULT_READY = 1'b0;
        check("midrst_s", S, 0);
        check("midrst_busy", BUSY, 0);
        check("midrst_done", DONE, 0);
        check("midrst_valid", RESULT_VALID, 0);
        check("midrst_result", RESULT, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            check("midrst_no_done", DONE, 0);
        end
        run_scan(20, 10, 1'b0, -1);

`ifdef RO_SCAN_MASK_EN
        CH_MASK = 6'b100100;
        run_scan(50, 10, 1'b1, -1);
        CH_MASK = 6'b000000;
        run_scan(50, 10, 1'b0, -1);
        CH_MASK = 6'b111111;
`endif

        // Saturation on the CNT_W=4 instance: 200/4 = 50 edges -> 15.
        ro_per = 4;
        ro_en = 1'b1;
        repeat (30) @(negedge CLK);
        start2 = 1'b1;
        window2 = 16'd200;
        @(negedge CLK);
        start2 = 1'b0;
        n = 0;
        while (!valid2 && n < 300) begin
            @(negedge CLK);
            n++;
        end
        check("sat_valid", valid2, 1);
        check("sat_result", result2, 15);
        check("sat_ch", result_ch2, 0);
        n = 0;
        while (!done2 && n < 2000) begin
            @(negedge CLK);
            n++;
        end
        check("sat_done", done2, 1);
        check("sat_busy", busy2, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
